// File: rtl/pwm_actuator.sv
// pwm_actuator
//   Output stage that turns a signed controller effort into a motor drive:
//   a PWM magnitude plus a direction bit. The duty is slew limited, changes
//   only at PWM period boundaries, and every direction reversal passes
//   through a forced-off dead window.
//
// Ports
//   clock         in   1                  system clock, all state on posedge
//   isReset       in   1                  asynchronous, active-high reset
//   controlValue  in   REGISTER_WIDTH     signed effort (two's complement)
//   controlValid  in   1                  controlValue is valid this cycle
//   controlReady  out  1                  a value can be accepted this cycle
//   pwmOut        out  1                  PWM drive to the power stage
//   direction     out  1                  0 = forward/positive, 1 = reverse
//   dutyCycle     out  REGISTER_WIDTH-1   currently applied duty, in counts
//   atTarget      out  1                  applied drive equals accepted target
module pwm_actuator #(
  parameter int REGISTER_WIDTH = 8,
  parameter int MAX_STEP       = 16,
  parameter int DEAD_CYCLES    = 4
) (
  input  logic                        clock,
  input  logic                        isReset,
  input  logic [REGISTER_WIDTH-1:0]   controlValue,
  input  logic                        controlValid,
  output logic                        controlReady,
  output logic                        pwmOut,
  output logic                        direction,
  output logic [REGISTER_WIDTH-2:0]   dutyCycle,
  output logic                        atTarget
);

  localparam int CW          = REGISTER_WIDTH - 1;
  localparam int P           = 2 ** CW;
  localparam int STEP_CLAMP  = (MAX_STEP > P - 1) ? (P - 1) : MAX_STEP;
  localparam int DW          = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] STEP_MAX = CW'(STEP_CLAMP);
  localparam logic [DW-1:0] DEAD_END = DW'(DEAD_CYCLES - 1);

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t              state_reg;
  logic [CW-1:0]       counter_reg;
  logic [CW-1:0]       duty_reg;
  logic                direction_reg;
  logic [CW-1:0]       t_mag_reg;
  logic                t_dir_reg;
  logic [DW-1:0]       dead_count_reg;

  // Target magnitude: |value| saturated to P-1. The most negative value
  // negates to itself, which shows up as the top bit set after negation.
  logic [REGISTER_WIDTH-1:0] neg_value;
  logic [REGISTER_WIDTH-1:0] abs_value;
  logic [CW-1:0]             value_mag;

  assign neg_value = ~controlValue + 1'b1;
  assign abs_value = controlValue[REGISTER_WIDTH-1] ? neg_value : controlValue;
  assign value_mag = abs_value[REGISTER_WIDTH-1] ? CNT_MAX : abs_value[CW-1:0];

  // Slew-limited step toward the current target, and the ramp-down used
  // while a reversal is pending.
  logic [CW-1:0] diff;
  logic [CW-1:0] step;
  logic [CW-1:0] duty_toward;
  logic [CW-1:0] duty_reverse;

  assign diff         = (t_mag_reg >= duty_reg) ? (t_mag_reg - duty_reg)
                                                : (duty_reg - t_mag_reg);
  assign step         = (diff > STEP_MAX) ? STEP_MAX : diff;
  assign duty_toward  = (t_mag_reg >= duty_reg) ? (duty_reg + step)
                                                : (duty_reg - step);
  assign duty_reverse = (duty_reg > STEP_MAX) ? (duty_reg - STEP_MAX) : '0;

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state_reg      <= RUN;
      counter_reg    <= '0;
      duty_reg       <= '0;
      direction_reg  <= 1'b0;
      t_mag_reg      <= '0;
      t_dir_reg      <= 1'b0;
      dead_count_reg <= '0;
    end else begin
      // Target load. The boundary logic below reads the old target, so a
      // value accepted on the boundary edge only takes effect one period on.
      if (controlValid && (state_reg == RUN)) begin
        t_mag_reg <= value_mag;
        t_dir_reg <= controlValue[REGISTER_WIDTH-1];
      end

      case (state_reg)
        RUN: begin
          if (counter_reg == CNT_MAX) begin
            counter_reg <= '0;
            if (t_dir_reg == direction_reg) begin
              duty_reg <= duty_toward;
            end else if (duty_reg != '0) begin
              duty_reg <= duty_reverse;
            end else begin
              state_reg      <= DEAD;
              dead_count_reg <= '0;
            end
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end

        DEAD: begin
          counter_reg <= '0;
          if (dead_count_reg == DEAD_END) begin
            // Output has been off for the whole window; safe to flip.
            direction_reg  <= t_dir_reg;
            state_reg      <= RUN;
            dead_count_reg <= '0;
          end else begin
            dead_count_reg <= dead_count_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them at once.
  assign controlReady = (state_reg == RUN);
  assign pwmOut       = (state_reg == RUN) && (counter_reg < duty_reg);
  assign direction    = direction_reg;
  assign dutyCycle    = duty_reg;
  assign atTarget     = (state_reg == RUN) && (direction_reg == t_dir_reg)
                        && (duty_reg == t_mag_reg);

endmodule
